ahb_dbg_sram_slave: RTL and testbench

- AHB slave (responder) with an internal word-organised SRAM.
- Serves as the target of debug-module system-bus accesses and of core AHB masters in bring-up and test builds.
- Supports byte, halfword and word accesses, programmable wait states, and the two-cycle AHB ERROR response for illegal accesses.
- Sits on the AHB data path behind the decoder (HSEL) and the HREADY mux.

---
 rtl/ahb_dbg_sram_slave.sv | 196 +++++++++++++++++++
 tb/tb_ahb_dbg_sram_slave.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_dbg_sram_slave.sv
// AHB-Lite SRAM responder used as the debug-module system-bus target.
// Word-organised array with byte/halfword/word access, fixed wait states
// before each OKAY completion and a two-cycle ERROR response for illegal
// accesses (misaligned, HSIZE>2, or beyond the array).

`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_dbg_sram_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       HSEL,
    input  logic [`AHB_ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]                 HTRANS,
    input  logic                       HWRITE,
    input  logic [2:0]                 HSIZE,
    input  logic [2:0]                 HBURST,
    input  logic [3:0]                 HPROT,
    input  logic [`AHB_DATA_WIDTH-1:0] HWDATA,
    input  logic                       HREADY,
    output logic                       HREADYOUT,
    output logic [1:0]                 HRESP,
    output logic [`AHB_DATA_WIDTH-1:0] HRDATA
);

    // Word index width for storage, plus one extra bit so that the first
    // out-of-range word (MEM_DEPTH) is still visible to the range check.
    localparam int WI_W  = $clog2(MEM_DEPTH);
    localparam int IDX_W = WI_W + 1;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [3:0]        cnt_r;
    logic [WI_W-1:0]   addr_r;
    logic [1:0]        lane_r;
    logic [1:0]        size_r;
    logic              write_r;
    logic              err_r;
    logic [IDX_W-1:0]  idx_s;
    logic              size_err_s;
    logic              err_s;
    logic              ready_state_s;
    logic              accept_s;
    logic              we_s;
    logic [3:0]        be_s;
    logic [31:0]       mem [MEM_DEPTH];

    // Address bits above the array window, HBURST and HPROT carry no meaning here.
    logic unused_s;
    assign unused_s = ^{HBURST, HPROT, HADDR[`AHB_ADDR_WIDTH-1:IDX_W+2]};

    // Byte-lane enables for a little-endian access of the given size.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd0:    lane_mask = 4'b0001 << lane;
            2'd1:    lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    assign idx_s = HADDR[IDX_W+1:2];

    // Address-phase legality: size/alignment and array range.
    always_comb begin
        case (HSIZE)
            3'd0:    size_err_s = 1'b0;
            3'd1:    size_err_s = HADDR[0];
            3'd2:    size_err_s = (HADDR[1:0] != 2'b00);
            default: size_err_s = 1'b1;
        endcase
        err_s = size_err_s | (idx_s >= IDX_W'(MEM_DEPTH));
    end

    // A new transfer can only be taken while no data phase is stalled.
    always_comb begin
        ready_state_s = (state_r == ST_IDLE) || (state_r == ST_LAST) || (state_r == ST_ERR2);
        accept_s      = HSEL & HREADY & HTRANS[1] & ready_state_s;
    end

    // Address-phase capture registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_r  <= '0;
            lane_r  <= 2'b00;
            size_r  <= 2'b00;
            write_r <= 1'b0;
            err_r   <= 1'b0;
        end else if (accept_s) begin
            addr_r  <= idx_s[WI_W-1:0];
            lane_r  <= HADDR[1:0];
            size_r  <= HSIZE[1:0];
            write_r <= HWRITE;
            err_r   <= err_s;
        end else begin
            addr_r  <= addr_r;
            lane_r  <= lane_r;
            size_r  <= size_r;
            write_r <= write_r;
            err_r   <= err_r;
        end
    end

    // Wait-state counter: reloaded on every accepted OKAY transfer, counts down in ST_WAIT.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_r <= 4'd0;
        end else if (accept_s && !err_s) begin
            cnt_r <= WS_LOAD;
        end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // FSM state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE, ST_LAST, ST_ERR2: begin
                if (!accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (err_s) begin
                    state_nxt_s = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_LAST;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_LAST;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ERR1: state_nxt_s = ST_ERR2;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs; read data comes straight from the array so a read right after a write sees it.
    always_comb begin
        HREADYOUT = !((state_r == ST_WAIT) || (state_r == ST_ERR1));
        HRESP     = ((state_r == ST_ERR1) || (state_r == ST_ERR2)) ? 2'b01 : 2'b00;
        if ((state_r == ST_LAST) && !write_r) begin
            HRDATA = mem[addr_r];
        end else begin
            HRDATA = '0;
        end
    end

    // Write strobe and lane enables for the completing data phase.
    always_comb begin
        we_s = (state_r == ST_LAST) & write_r & ~err_r;
        be_s = lane_mask(size_r, lane_r);
    end

    // SRAM array write; contents are deliberately not reset.
    always_ff @(posedge HCLK) begin
        if (we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem[addr_r][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_dbg_sram_slave.sv
// Bench for ahb_dbg_sram_slave: two instances (0 and 3 wait states) on
// separate selects. A driver issues pipelined AHB transfers and queues the
// expected data-phase response; a monitor follows the bus protocol and
// compares each completed data phase against the head of the queue.

module tb_ahb_dbg_sram_slave;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        bus_hsel = 1'b0;
    logic [31:0] HADDR = 32'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b000;
    logic [31:0] HWDATA = 32'h0;
    logic        sel3 = 1'b0;

    logic        hsel0, hsel3;
    logic        ready0, ready3;
    logic [1:0]  resp0, resp3;
    logic [31:0] rdata0, rdata3;

    int errs = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [1:0]  resp;
        int          waits;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    assign hsel0 = bus_hsel & ~sel3;
    assign hsel3 = bus_hsel & sel3;

    always #5 HCLK = ~HCLK;

    ahb_dbg_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000),
        .HPROT(4'b0011), .HWDATA(HWDATA), .HREADY(ready0),
        .HREADYOUT(ready0), .HRESP(resp0), .HRDATA(rdata0)
    );

    ahb_dbg_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000),
        .HPROT(4'b0011), .HWDATA(HWDATA), .HREADY(ready3),
        .HREADYOUT(ready3), .HRESP(resp3), .HRDATA(rdata3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Present one address phase, queue its expected response, hold until accepted.
    task automatic xfer(input string nm, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic err, input logic [31:0] rd);
        exp_t e;
        bit   r;
        int   n;
        bus_hsel = 1'b1;
        HTRANS   = 2'b10;
        HWRITE   = wr;
        HSIZE    = sz;
        HADDR    = a;
        e.name   = nm;
        e.resp   = err ? 2'b01 : 2'b00;
        e.waits  = err ? 1 : (sel3 ? 3 : 0);
        e.rdata  = (wr || err) ? 32'h0 : rd;
        sb.push_back(e);
        r = 1'b0;
        n = 0;
        while (!r && n < 50) begin
            @(negedge HCLK);
            r = sel3 ? ready3 : ready0;
            @(posedge HCLK);
            #1;
            n++;
        end
        if (!r) begin
            checks++;
            errs++;
            $display("FAIL accept_timeout %s: got no HREADY expected HREADY=1 within 50 cycles", nm);
        end
        HWDATA   = wd;
        bus_hsel = 1'b0;
        HTRANS   = 2'b00;
    endtask

    task automatic idle(input int n);
        bus_hsel = 1'b0;
        HTRANS   = 2'b00;
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    // One cycle of arbitrary non-accepted bus activity.
    task automatic raw(input logic s, input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd);
        bus_hsel = s;
        HTRANS   = t;
        HWRITE   = 1'b1;
        HSIZE    = 3'b010;
        HADDR    = a;
        HWDATA   = wd;
        @(posedge HCLK);
        #1;
    endtask

    // Protocol monitor: tracks data phases on the selected instance and scores them.
    bit dp = 1'b0;
    int lowcnt = 0;
    always @(negedge HCLK) begin
        logic        rdy;
        logic [1:0]  rsp;
        logic [31:0] rdt;
        exp_t        e;
        rdy = sel3 ? ready3 : ready0;
        rsp = sel3 ? resp3 : resp0;
        rdt = sel3 ? rdata3 : rdata0;
        if (!HRESETn) begin
            chk("reset_hreadyout", {31'h0, rdy}, 32'h1);
            chk("reset_hresp", {30'h0, rsp}, 32'h0);
            chk("reset_hrdata", rdt, 32'h0);
            dp = 1'b0;
            lowcnt = 0;
            sb.delete();
        end else begin
            if (dp) begin
                if (sb.size() == 0) begin
                    chk("orphan_data_phase", 32'h1, 32'h0);
                    dp = 1'b0;
                end else begin
                    e = sb[0];
                    if (!rdy) begin
                        lowcnt++;
                        chk({e.name, "_wait_hresp"}, {30'h0, rsp}, {30'h0, e.resp});
                        chk({e.name, "_wait_hrdata"}, rdt, 32'h0);
                    end else begin
                        void'(sb.pop_front());
                        chk({e.name, "_waits"}, lowcnt, e.waits);
                        chk({e.name, "_hresp"}, {30'h0, rsp}, {30'h0, e.resp});
                        chk({e.name, "_hrdata"}, rdt, e.rdata);
                        lowcnt = 0;
                    end
                end
            end else begin
                chk("idle_hreadyout", {31'h0, rdy}, 32'h1);
                chk("idle_hresp", {30'h0, rsp}, 32'h0);
                chk("idle_hrdata", rdt, 32'h0);
            end
            if (rdy) begin
                dp = bus_hsel && HTRANS[1];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        HRESETn = 1'b1;
        idle(2);

        // Zero wait states: pipelined writes and reads.
        sel3 = 1'b0;
        xfer("w_w0",   1'b1, 3'b010, 32'h00, 32'hCAFEF00D, 1'b0, 32'h0);
        xfer("w_w10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        xfer("r_w10",  1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
        xfer("w_w20",  1'b1, 3'b010, 32'h20, 32'h00000000, 1'b0, 32'h0);
        xfer("w_b21",  1'b1, 3'b000, 32'h21, 32'h00001100, 1'b0, 32'h0);
        xfer("w_h22",  1'b1, 3'b001, 32'h22, 32'hAABB0000, 1'b0, 32'h0);
        xfer("r_w20",  1'b0, 3'b010, 32'h20, 32'h0,        1'b0, 32'hAABB1100);
        xfer("r_b21",  1'b0, 3'b000, 32'h21, 32'h0,        1'b0, 32'hAABB1100);
        idle(2);

        // Illegal accesses, then an uncancelled transfer accepted in the second error cycle.
        xfer("e_w02",  1'b1, 3'b010, 32'h02,  32'h12345678, 1'b1, 32'h0);
        xfer("e_sz3",  1'b1, 3'b011, 32'h00,  32'h87654321, 1'b1, 32'h0);
        xfer("e_oor",  1'b1, 3'b010, 32'h400, 32'h0F0F0F0F, 1'b1, 32'h0);
        xfer("e_h11",  1'b1, 3'b001, 32'h11,  32'h55550000, 1'b1, 32'h0);
        xfer("r_aft",  1'b0, 3'b010, 32'h00,  32'h0,        1'b0, 32'hCAFEF00D);
        xfer("r_w10b", 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
        idle(2);

        // Non-accepted cycles: BUSY, IDLE, unselected NONSEQ.
        raw(1'b1, 2'b01, 32'h10, 32'h11111111);
        raw(1'b1, 2'b00, 32'h10, 32'h22222222);
        raw(1'b0, 2'b10, 32'h10, 32'h33333333);
        idle(1);
        xfer("r_w10c", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        idle(2);

        // Three wait states.
        sel3 = 1'b1;
        idle(1);
        xfer("w3_w30", 1'b1, 3'b010, 32'h30, 32'h55AA55AA, 1'b0, 32'h0);
        xfer("r3_w30", 1'b0, 3'b010, 32'h30, 32'h0,        1'b0, 32'h55AA55AA);
        idle(3);
        xfer("r3_one", 1'b0, 3'b000, 32'h33, 32'h0,        1'b0, 32'h55AA55AA);
        xfer("e3_sz3", 1'b0, 3'b011, 32'h30, 32'h0,        1'b1, 32'h0);
        idle(3);

        // Reset while a write sits in its wait states.
        xfer("w3_rst", 1'b1, 3'b010, 32'h30, 32'h0BADBEEF, 1'b0, 32'h0);
        bus_hsel = 1'b0;
        HTRANS   = 2'b00;
        HRESETn  = 1'b0;
        idle(2);
        HRESETn  = 1'b1;
        idle(2);
        xfer("r3_kept", 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'h55AA55AA);
        idle(6);
        sel3 = 1'b0;
        idle(1);
        xfer("r0_kept", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hAABB1100);
        idle(4);

        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
